avalon_ram_bridge: RTL

Slave-side bridge between the MIPS CPU's byte-addressed Avalon-style data/instruction port and a 32x4096 word RAM. The RAM has a one-cycle registered read and no byte enables. The bridge performs address translation, range and alignment checking, and read-modify-write for partial-word stores. It also inserts optional wait states. It sits directly upstream of the RAM, between the CPU bus and the RAM's clk/address/write/read/writedata/readdata pins.

---
 rtl/avalon_ram_bridge_if.sv | 26 ++
 rtl/avalon_ram_bridge.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/avalon_ram_bridge_if.sv
// ============================================================================
// avalon_ram_bridge_if : CPU-side Avalon-style bus, byte addressed | rev 1.0
// ============================================================================
`default_nettype none

interface avalon_ram_bridge_if;
  logic [31:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
    input  avs_waitrequest, avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
    output avs_waitrequest, avs_readdata
  );
endinterface

`default_nettype wire

// File: rtl/avalon_ram_bridge.sv
// ============================================================================
// avalon_ram_bridge : CPU bus to 32x4096 word RAM, RMW for partial stores | rev 1.0
// ============================================================================
`default_nettype none

module avalon_ram_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  avalon_ram_bridge_if.slave  avs,
  output logic [11:0]         ram_address,
  output logic                ram_read,
  output logic                ram_write,
  output logic [31:0]         ram_writedata,
  input  wire logic [31:0]    ram_readdata,
  output logic                err
);

  localparam bit       C_HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [2:0] C_WS     = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STALL = 3'd1,
    S_RD    = 3'd2,
    S_RMW   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic        w_rd;
  logic        w_wr;
  logic [31:0] w_offset;
  logic        w_addr_ok;
  logic        w_issue;
  logic [31:0] w_merged;

  assign w_req = avs.avs_read | avs.avs_write;

  // In IDLE the request is issued from the live bus; afterwards from the latched copy.
  assign w_addr  = (state_q == S_IDLE) ? avs.avs_address    : addr_q;
  assign w_wdata = (state_q == S_IDLE) ? avs.avs_writedata  : wdata_q;
  assign w_be    = (state_q == S_IDLE) ? avs.avs_byteenable : be_q;
  assign w_rd    = (state_q == S_IDLE) ? avs.avs_read       : rd_q;
  assign w_wr    = (state_q == S_IDLE) ? avs.avs_write      : wr_q;

  assign w_offset    = w_addr - BASE_ADDR;
  assign w_addr_ok   = (w_offset[1:0] == 2'b00) && (w_offset[31:14] == 18'd0);
  assign ram_address = w_offset[13:2];

  assign w_issue = reset_n &&
                   (((state_q == S_IDLE) && w_req && !C_HAS_WAIT) ||
                    ((state_q == S_STALL) && (cnt_q == 3'd1)));

  always_comb begin
    w_merged = ram_readdata;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) w_merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    be_d          = be_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    err_d         = err_q;
    ram_read      = 1'b0;
    ram_write     = 1'b0;
    ram_writedata = w_wdata;

    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          addr_d  = avs.avs_address;
          wdata_d = avs.avs_writedata;
          be_d    = avs.avs_byteenable;
          rd_d    = avs.avs_read;
          wr_d    = avs.avs_write;
          if (C_HAS_WAIT) begin
            cnt_d   = C_WS;
            state_d = S_STALL;
          end
        end
      end
      S_STALL: begin
        cnt_d = cnt_q - 3'd1;
      end
      S_RD: begin
        rdata_d = ram_readdata;
        state_d = S_DONE;
      end
      S_RMW: begin
        ram_write     = reset_n;
        ram_writedata = w_merged;
        state_d       = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_issue) begin
      if (!w_addr_ok || (w_rd && w_wr)) begin
        err_d   = 1'b1;
        rdata_d = 32'd0;
        state_d = S_DONE;
      end else if (w_rd) begin
        ram_read = 1'b1;
        state_d  = S_RD;
      end else if (w_be == 4'hF) begin
        ram_write     = 1'b1;
        ram_writedata = w_wdata;
        state_d       = S_DONE;
      end else if (w_be == 4'h0) begin
        state_d = S_DONE;
      end else begin
        ram_read = 1'b1;
        state_d  = S_RMW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      be_q    <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  assign avs.avs_waitrequest = w_req && (state_q != S_DONE);
  assign avs.avs_readdata    = rdata_q;
  assign err                 = err_q;

endmodule

`default_nettype wire
